vga_timing_addr_gen: RTL
========================

Name: vga_timing_addr_gen

Overview:
- Upstream stage of vga_ram_block: generates 640x480@60 Hz VGA timing from the system clock.
- Produces the frame-buffer read address for a 256x256 8-bit grayscale image centred on screen.
- Pipelines hsync/vsync/blank so they stay aligned with the pixel returned by the RAM; drives grayscale RGB (black outside the image).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- IMG_W, 256, image width (power of two)
- IMG_H, 256, image height
- IMG_X0, 192, image left column
- IMG_Y0, 112, image top line

Ports:
- clk  in  1  system clock (50 MHz); sole clock
- rst  in  1  synchronous, active-high reset
- pixelValue  in  8  RAM read data, valid one pixel tick after readAddress
- vga_clk  out  1  pixel clock = clk/2, registered
- readAddress  out  16  frame-buffer address
- Hsync  out  1  active-low horizontal sync
- Vsync  out  1  active-low vertical sync
- VGA_Blank  out  1  high = visible pixel
- VGA_Sync  out  1  composite sync, constant 0
- Red  out  8  pixel red
- Green  out  8  pixel green
- Blue  out  8  pixel blue
- frame_start  out  1  one-clk pulse at hc=0, vc=0 tick

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- Pixel enable: pix_en toggles every clk; it is 1 on every second clk. vga_clk is a register toggled each clk, rising on the clk where pix_en=1. All stages below advance only when pix_en=1.
- Counters:
  - hc runs 0..H_TOTAL-1 (799); vc runs 0..V_TOTAL-1 (524).
  - vc increments when hc wraps 799->0; vc wraps 524->0 in the same tick.
- Stage 0 (combinational from counters):
  - active = hc<640 && vc<480
  - hs_n = !(656<=hc<=751)
  - vs_n = !(490<=vc<=491)
  - in_img = IMG_X0<=hc<IMG_X0+IMG_W && IMG_Y0<=vc<IMG_Y0+IMG_H
- Stage 1 (registered):
  - readAddress = ((vc-IMG_Y0)<<8) | (hc-IMG_X0), truncated to 16 bits, when in_img; otherwise 0.
  - Also registers hs_n, vs_n, active, in_img.
- Stage 2 (registered):
  - Red/Green/Blue = pixelValue when the stage-1 in_img and active are both 1; otherwise 0.
  - Hsync/Vsync/VGA_Blank take the stage-1 copies.
- Latency: 2 pixel ticks (4 clk) from a counter value to its RGB/sync/blank. readAddress leads RGB by exactly 1 pixel tick.
- Address sequence: 0..65535 across the image rows. First address 0 at (hc=192, vc=112); last address 65535 at (hc=447, vc=367).
- frame_start: high for one clk, on the pix_en clk where hc=0 and vc=0.
- Reset:
  - hc=0, vc=0, pix_en=0, vga_clk=0, readAddress=0.
  - Hsync=1, Vsync=1, VGA_Blank=0, RGB=0, frame_start=0.
  - All pipeline registers are cleared.
- Reset mid-frame: the same values apply on the next clk. Timing restarts at hc=0, vc=0 with no partial sync pulse, and the first pix_en occurs on the second clk after rst falls.
- VGA_Sync is driven 0 at all times.

Decomposition:
- Package vga_pkg:
  - timing constants H_TOTAL=800, V_TOTAL=525
  - sync start/end constants
  - typedefs: pix_t (logic [7:0]), addr_t (logic [15:0]), coord_t (logic [9:0])
- Sub-module vga_counter: pix_en-gated hc/vc counter with wrap, outputs hc, vc and line_end.
- Sync decode, address calculation and the pipeline stay in the top module.

Test Plan:
- rst held 3 clk, then released -> Hsync=1, Vsync=1, VGA_Blank=0, RGB=0, readAddress=0; vga_clk toggles every clk with period 2 clk.
- Run one line -> Hsync low for exactly 96 pixel ticks (192 clk), starting 2 ticks after hc=656; line period 1600 clk.
- Run one frame -> Vsync low for 2 lines (3200 clk); frame period 840000 clk; frame_start pulses once per frame.
- At (hc=192, vc=112), readAddress=0; at (193,112), readAddress=1; at (192,113), readAddress=256; at (447,367), readAddress=65535; outside the image, readAddress=0.
- RAM model returning pixelValue = address[7:0] with 1-tick latency -> at screen (200,112), Red=Green=Blue=8; at (100,200), RGB=0 while VGA_Blank=1.
- Assert rst at hc=300, vc=250 for 1 clk -> next clk all outputs are at reset values; counting resumes from hc=0, vc=0; the next Vsync pulse occurs 490 lines later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA timing / address generator.
package vga_pkg;

    typedef logic [7:0]  pix_t;
    typedef logic [15:0] addr_t;
    typedef logic [9:0]  coord_t;

    // 640x480@60 Hz geometry and the centred 256x256 image
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned IMG_W_DEF    = 256;
    localparam int unsigned IMG_H_DEF    = 256;
    localparam int unsigned IMG_X0_DEF   = 192;
    localparam int unsigned IMG_Y0_DEF   = 112;

    localparam int unsigned H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned HS_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned HS_END   = HS_START + H_SYNC_DEF - 1;
    localparam int unsigned VS_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned VS_END   = VS_START + V_SYNC_DEF - 1;

endpackage

// File: rtl/vga_counter.sv
// Pixel-enable gated horizontal/vertical position counter with frame wrap.
module vga_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_TOT = H_TOTAL,
    parameter int unsigned V_TOT = V_TOTAL
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pix_en,
    output coord_t hc,
    output coord_t vc,
    output logic   line_end
);

    localparam coord_t H_LAST = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST = coord_t'(V_TOT - 1);

    assign line_end = (hc == H_LAST);

    // Advance one pixel per tick; the line counter steps and wraps on line end
    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_addr_gen.sv
// VGA timing generator producing frame-buffer read addresses for a centred
// grayscale image, with sync/blank pipelined to line up with RAM read data.
module vga_timing_addr_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned IMG_W    = IMG_W_DEF,
    parameter int unsigned IMG_H    = IMG_H_DEF,
    parameter int unsigned IMG_X0   = IMG_X0_DEF,
    parameter int unsigned IMG_Y0   = IMG_Y0_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  pix_t  pixelValue,
    output logic  vga_clk,
    output addr_t readAddress,
    output logic  Hsync,
    output logic  Vsync,
    output logic  VGA_Blank,
    output logic  VGA_Sync,
    output pix_t  Red,
    output pix_t  Green,
    output pix_t  Blue,
    output logic  frame_start
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t HA     = coord_t'(H_ACTIVE);
    localparam coord_t VA     = coord_t'(V_ACTIVE);
    localparam coord_t HS_S   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_E   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_S   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_E   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam coord_t IX0    = coord_t'(IMG_X0);
    localparam coord_t IX1    = coord_t'(IMG_X0 + IMG_W);
    localparam coord_t IY0    = coord_t'(IMG_Y0);
    localparam coord_t IY1    = coord_t'(IMG_Y0 + IMG_H);
    localparam coord_t V_LAST = coord_t'(V_TOT - 1);
    localparam addr_t  IX0_A  = addr_t'(IMG_X0);
    localparam addr_t  IY0_A  = addr_t'(IMG_Y0);
    localparam int unsigned IMG_SHIFT = $clog2(IMG_W);

    logic   pix_en;
    logic   frame_origin;
    coord_t hc;
    coord_t vc;
    logic   line_end;

    // stage 0
    logic   active0;
    logic   hs_n0;
    logic   vs_n0;
    logic   in_img0;
    addr_t  x_off;
    addr_t  y_off;
    addr_t  img_addr;

    // stage 1
    logic   hs_n1;
    logic   vs_n1;
    logic   active1;
    logic   in_img1;

    vga_counter #(
        .H_TOT (H_TOT),
        .V_TOT (V_TOT)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .hc       (hc),
        .vc       (vc),
        .line_end (line_end)
    );

    // Pixel enable and the exported pixel clock both toggle every clk
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_en  <= 1'b0;
            vga_clk <= 1'b0;
        end else begin
            pix_en  <= ~pix_en;
            vga_clk <= ~vga_clk;
        end
    end

    // Flags that the counters sit at (0,0); set by reset or predicted from the
    // last pixel of the frame so no wide compare on hc/vc is needed
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_origin <= 1'b1;
        end else if (pix_en) begin
            frame_origin <= line_end && (vc == V_LAST);
        end
    end

    assign frame_start = pix_en & frame_origin;
    assign VGA_Sync    = 1'b0;

    // Stage 0: decode visibility, sync windows and image address from position
    always_comb begin
        active0  = (hc < HA) && (vc < VA);
        hs_n0    = !((hc >= HS_S) && (hc <= HS_E));
        vs_n0    = !((vc >= VS_S) && (vc <= VS_E));
        in_img0  = (hc >= IX0) && (hc < IX1) && (vc >= IY0) && (vc < IY1);
        x_off    = addr_t'(hc) - IX0_A;
        y_off    = addr_t'(vc) - IY0_A;
        img_addr = (y_off << IMG_SHIFT) | x_off;
    end

    // Stage 1: register read address and the control flags that travel with it
    always_ff @(posedge clk) begin
        if (rst) begin
            readAddress <= '0;
            hs_n1       <= 1'b1;
            vs_n1       <= 1'b1;
            active1     <= 1'b0;
            in_img1     <= 1'b0;
        end else if (pix_en) begin
            readAddress <= in_img0 ? img_addr : '0;
            hs_n1       <= hs_n0;
            vs_n1       <= vs_n0;
            active1     <= active0;
            in_img1     <= in_img0;
        end
    end

    // Stage 2: capture RAM data as grayscale and align sync/blank with it
    always_ff @(posedge clk) begin
        if (rst) begin
            Hsync     <= 1'b1;
            Vsync     <= 1'b1;
            VGA_Blank <= 1'b0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
        end else if (pix_en) begin
            Hsync     <= hs_n1;
            Vsync     <= vs_n1;
            VGA_Blank <= active1;
            Red       <= (in_img1 && active1) ? pixelValue : '0;
            Green     <= (in_img1 && active1) ? pixelValue : '0;
            Blue      <= (in_img1 && active1) ? pixelValue : '0;
        end
    end

endmodule
